vtiming_gen: RTL

//  Parametrised vertical timing generator; successor to the fixed 640x480@60 vsync block.
//  - Counts lines, advancing once per i_ven pulse from the horizontal generator.
//  - Runs a 4-region FSM (SYNC/BACK/ACTIVE/FRONT) and drives the sync pulse, active-area enable and visible line index.
//  - Emits a delayed one-clock frame-start strobe for the pixel/address pipeline.
//  - Timing set per instance, so one block serves every VGA mode.

---
 rtl/vtiming_gen_pkg.sv | 24 ++
 rtl/vtiming_gen_shift_left_register.sv | 37 +++
 rtl/vtiming_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vtiming_gen_pkg.sv
// Shared vertical/horizontal timing definitions: region encodings and region boundary formulas.
// No logic, no latency; the hsync counterpart imports the same package.
package vtiming_gen_pkg;

  typedef enum logic [1:0] {
    REG_SYNC   = 2'd0,
    REG_BACK   = 2'd1,
    REG_ACTIVE = 2'd2,
    REG_FRONT  = 2'd3
  } region_e;

  function automatic int vt_total(int sync_l, int back_l, int vis_l, int front_l);
    return sync_l + back_l + vis_l + front_l;
  endfunction

  function automatic int vt_act_start(int sync_l, int back_l);
    return sync_l + back_l;
  endfunction

  function automatic int vt_front_start(int sync_l, int back_l, int vis_l);
    return sync_l + back_l + vis_l;
  endfunction

endpackage

// File: rtl/vtiming_gen_shift_left_register.sv
// shift_left_register: delay line, q_o[WIDTH-1] is d_i delayed WIDTH clocks.
// Async active-low reset plus synchronous clear that empties every stage; no backpressure.
module shift_left_register #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d    = q_q << 1;
    q_d[0] = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (i_sclr_hold(sclr_i)) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  function automatic logic i_sclr_hold(input logic s);
    return s;
  endfunction

  assign q_o = q_q;

endmodule

// File: rtl/vtiming_gen.sv
// Vertical timing generator: line counter + SYNC/BACK/ACTIVE/FRONT FSM, outputs registered on the i_ven edge.
// Frame strobe lags top-of-frame by 1+FRAME_DLY clocks; no backpressure. VTIMING_LINE_MATCH_EN adds a line-match pulse.
module vtiming_gen
  import vtiming_gen_pkg::*;
#(
  parameter int SYNC_LINES    = 2,
  parameter int BACK_LINES    = 33,
  parameter int VIS_LINES     = 480,
  parameter int FRONT_LINES   = 10,
  parameter int CNT_W         = 10,
  parameter int IDX_W         = 9,
  parameter bit SYNC_ACT_HIGH = 1'b1,
  parameter int FRAME_DLY     = 2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_sclr,
  input  logic             i_ven,
  output logic             o_vsync,
  output logic             o_addr_enb,
  output logic [IDX_W-1:0] o_idx,
  output logic [1:0]       o_region,
  output logic             o_frame_en
`ifdef VTIMING_LINE_MATCH_EN
  ,
  output logic             o_line_match,
  input  logic [IDX_W-1:0] i_match_line
`endif
);

  localparam int TOTAL       = vt_total(SYNC_LINES, BACK_LINES, VIS_LINES, FRONT_LINES);
  localparam int ACT_START   = vt_act_start(SYNC_LINES, BACK_LINES);
  localparam int FRONT_START = vt_front_start(SYNC_LINES, BACK_LINES, VIS_LINES);

  localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] L_BACK  = CNT_W'(SYNC_LINES);
  localparam logic [CNT_W-1:0] L_ACT   = CNT_W'(ACT_START);
  localparam logic [CNT_W-1:0] L_FRONT = CNT_W'(FRONT_START);

  region_e          region_q, region_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic             vsync_q, vsync_d;
  logic             addr_enb_q, addr_enb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      off_d;
  logic             top;
  logic             top_q;
  logic             rise_q;

  assign top = (line_q == '0);

  // State register: counter, region, registered outputs and the top-of-frame edge detector.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_q     <= '0;
      region_q   <= REG_SYNC;
      vsync_q    <= SYNC_ACT_HIGH;
      addr_enb_q <= 1'b0;
      idx_q      <= '0;
      top_q      <= 1'b0;
      rise_q     <= 1'b0;
    end else if (i_sclr) begin
      line_q     <= '0;
      region_q   <= REG_SYNC;
      vsync_q    <= SYNC_ACT_HIGH;
      addr_enb_q <= 1'b0;
      idx_q      <= '0;
      top_q      <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      line_q     <= line_d;
      region_q   <= region_d;
      vsync_q    <= vsync_d;
      addr_enb_q <= addr_enb_d;
      idx_q      <= idx_d;
      top_q      <= top;
      rise_q     <= top & ~top_q;
    end
  end

  // Next state: region changes on the same i_ven edge that moves the line onto a boundary.
  always_comb begin
    line_d   = line_q;
    region_d = region_q;
    if (i_ven) begin
      line_d = (line_q == L_LAST) ? '0 : line_q + 1'b1;
      case (region_q)
        REG_SYNC:   if (line_d == L_BACK)  region_d = REG_BACK;
        REG_BACK:   if (line_d == L_ACT)   region_d = REG_ACTIVE;
        REG_ACTIVE: if (line_d == L_FRONT) region_d = REG_FRONT;
        REG_FRONT:  if (line_d == '0)      region_d = REG_SYNC;
        default:                           region_d = REG_SYNC;
      endcase
    end
  end

  // Output decode of the next state, so the output registers track line_q exactly.
  always_comb begin
    off_d      = 32'(line_d) - 32'(ACT_START);
    vsync_d    = (region_d == REG_SYNC) ? SYNC_ACT_HIGH : ~SYNC_ACT_HIGH;
    addr_enb_d = (region_d == REG_ACTIVE);
    idx_d      = addr_enb_d ? IDX_W'(off_d) : '0;
  end

  assign o_vsync    = vsync_q;
  assign o_addr_enb = addr_enb_q;
  assign o_idx      = idx_q;
  assign o_region   = region_q;

  generate
    if (FRAME_DLY == 0) begin : g_no_dly
      assign o_frame_en = rise_q;
    end else begin : g_dly
      logic [FRAME_DLY-1:0] dly;
      shift_left_register #(
        .WIDTH (FRAME_DLY)
      ) u_frame_dly (
        .clk    (clk),
        .rst_n  (i_rst_n),
        .sclr_i (i_sclr),
        .d_i    (rise_q),
        .q_o    (dly)
      );
      assign o_frame_en = dly[FRAME_DLY-1];
    end
  endgenerate

`ifdef VTIMING_LINE_MATCH_EN
  logic line_match_q;
  logic line_match_d;

  // Only the edge that enters the line fires; an out-of-range index never equals off_d inside ACTIVE.
  assign line_match_d = i_ven & addr_enb_d & (off_d == 32'(i_match_line));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_match_q <= 1'b0;
    end else if (i_sclr) begin
      line_match_q <= 1'b0;
    end else begin
      line_match_q <= line_match_d;
    end
  end

  assign o_line_match = line_match_q;
`endif

endmodule
